counter_mod_k_ro: RTL and testbench

//   Free-running modulo-k counter with runtime-programmable modulus k and a registered
//   one-cycle roll-over pulse.

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_mod_k_core.sv | 40 ++++
 rtl/counter_mod_k_ro.sv | 50 +++++
 tb/tb_counter_mod_k_ro.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared width default and wrap-condition helper for the modulo-k counter.
package counter_pkg;

  localparam int unsigned COUNTER_N_DEFAULT = 2;
  localparam int unsigned COUNTER_W_MAX     = 32;

  // k==0 never wraps (counter disabled); k==1 wraps every cycle since count>=0 always holds.
  function automatic logic is_wrap(input logic [COUNTER_W_MAX-1:0] count,
                                   input logic [COUNTER_W_MAX-1:0] k);
    if (k == '0) begin
      return 1'b0;
    end
    return count >= (k - 1);
  endfunction

endpackage

// File: rtl/counter_mod_k_core.sv
// Count register and wrap detection for the modulo-k counter.
module counter_mod_k_core
  import counter_pkg::*;
#(
  parameter int unsigned N = COUNTER_N_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [N-1:0] i_k,
  output logic [N-1:0] o_count,
  output logic         o_wrap
);

  logic [N-1:0] count_q, count_d;
  logic         wrap;

  always_comb begin
    wrap = is_wrap(COUNTER_W_MAX'(count_q), COUNTER_W_MAX'(i_k));
  end

  always_comb begin
    count_d = count_q + N'(1);
    // A disabled counter (k==0) is pinned at zero rather than left free-running.
    if (i_k == '0 || wrap) begin
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_wrap  = wrap;

endmodule

// File: rtl/counter_mod_k_ro.sv
// Free-running modulo-k counter with a registered one-cycle roll-over pulse.
// Define COUNTER_MOD_K_RO_COUNT_OUT_EN to expose the current count on o_count.
module counter_mod_k_ro
  import counter_pkg::*;
#(
  parameter int unsigned N = COUNTER_N_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [N-1:0] i_k,
  output logic         o_roll_over
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
  ,
  output logic [N-1:0] o_count
`endif
);

  logic [N-1:0] count;
  logic         wrap;
  logic         roll_q;

  counter_mod_k_core #(
    .N(N)
  ) u_core (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_k      (i_k),
    .o_count  (count),
    .o_wrap   (wrap)
  );

  // The pulse lands in the cycle where the count has just returned to zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      roll_q <= 1'b0;
    end else begin
      roll_q <= wrap;
    end
  end

  assign o_roll_over = roll_q;

`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
  assign o_count = count;
`else
  logic unused_count;
  assign unused_count = ^count;
`endif

endmodule

// File: tb/tb_counter_mod_k_ro.sv
// Directed bench for counter_mod_k_ro: an N=2 and an N=4 instance checked against an
// integer model every cycle, plus literal pulse patterns sampled mid-cycle.
module tb_counter_mod_k_ro;

  logic       clk;
  logic       rst_a, rst_b;
  logic [1:0] k_a;
  logic [3:0] k_b;
  logic       roll_a, roll_b;
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
  logic [1:0] cnt_a;
  logic [3:0] cnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  counter_mod_k_ro #(
    .N(2)
  ) dut_a (
    .i_clk      (clk),
    .i_reset_n  (rst_a),
    .i_k        (k_a),
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
    .o_count    (cnt_a),
`endif
    .o_roll_over(roll_a)
  );

  counter_mod_k_ro #(
    .N(4)
  ) dut_b (
    .i_clk      (clk),
    .i_reset_n  (rst_b),
    .i_k        (k_b),
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
    .o_count    (cnt_b),
`endif
    .o_roll_over(roll_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count advances modulo k; reaching or overshooting k-1 wraps to 0 with a pulse.
  task automatic model_step(input int cnt, input int k, input logic rst_n,
                            output int ncnt, output int nroll);
    if (!rst_n || k == 0) begin
      ncnt  = 0;
      nroll = 0;
    end else if (cnt + 1 >= k) begin
      ncnt  = 0;
      nroll = 1;
    end else begin
      ncnt  = cnt + 1;
      nroll = 0;
    end
  endtask

  int m_cnt_a = 0, m_roll_a = 0;
  int m_cnt_b = 0, m_roll_b = 0;

  always @(posedge clk) begin
    int nc, nr;
    model_step(m_cnt_a, int'(k_a), rst_a, nc, nr);
    m_cnt_a  = nc;
    m_roll_a = nr;
    model_step(m_cnt_b, int'(k_b), rst_b, nc, nr);
    m_cnt_b  = nc;
    m_roll_b = nr;
    #1;
    check("model_roll_a", 32'(roll_a), m_roll_a);
    check("model_roll_b", 32'(roll_b), m_roll_b);
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
    check("model_cnt_a", 32'(cnt_a), m_cnt_a);
    check("model_cnt_b", 32'(cnt_b), m_cnt_b);
`endif
  end

  // pat bit i is the roll-over level expected at the i-th following mid-cycle sample.
  task automatic run_a(input string name, input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, 32'(roll_a), 32'(pat[i]));
    end
  endtask

  task automatic seq_a();
    @(negedge clk);
    check("t1_reset", 32'(roll_a), 0);
    rst_a = 1'b1;
    run_a("t1_k3", 9, 16'b1_0010_0100);

    run_a("t4_pre", 2, 16'b00);
    rst_a = 1'b0;
    @(negedge clk);
    check("t4_reset", 32'(roll_a), 0);
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
    check("t4_reset_cnt", 32'(cnt_a), 0);
`endif
    rst_a = 1'b1;
    run_a("t4_post", 3, 16'b100);

    run_a("t5_pre", 2, 16'b00);
    k_a = 2'd2;
    run_a("t5_k2", 5, 16'b10101);

    rst_a = 1'b0;
    k_a   = 2'd1;
    @(negedge clk);
    check("t2_reset", 32'(roll_a), 0);
    rst_a = 1'b1;
    run_a("t2_k1", 5, 16'b11111);

    k_a = 2'd0;
    run_a("t3_k0", 10, 16'b0);
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
    check("t3_k0_cnt", 32'(cnt_a), 0);
`endif
  endtask

  task automatic seq_b();
    int pulses = 0;
    int first  = -1;
    @(negedge clk);
    check("t6_reset", 32'(roll_b), 0);
    rst_b = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (roll_b === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check("t6_pulses", 32'(pulses), 4);
    check("t6_first", 32'(first), 15);
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    k_a   = 2'd3;
    k_b   = 4'd15;
    fork
      seq_a();
      seq_b();
    join
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
